sram_mixed_readfirst: RTL and testbench

SRAM_MIXED_READFIRST -- requirements
Module: sram_mixed_readfirst

---
 rtl/sram_mixed_readfirst_pkg.sv | 33 +++
 rtl/sram_v2l.sv | 22 ++
 rtl/sram_mixed_readfirst.sv | 90 +++++++++
 tb/tb_sram_mixed_readfirst.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_mixed_readfirst_pkg.sv
// Purpose: shared supply constants and voltage<->logic conversion helpers for the mixed-signal SRAM.
// Latency: pure functions, no state.
// Backpressure: none.
package sram_mixed_readfirst_pkg;

    // Nominal logic-high supply in volts.
    localparam real VDD_DEFAULT = 1.8;

    // Decision threshold for the nominal supply.
    localparam real VTH_DEFAULT = VDD_DEFAULT / 2.0;

    // Threshold for an arbitrary supply: half of the rail.
    function automatic real vth(input real vdd);
        return vdd / 2.0;
    endfunction

    // A NaN is the only real that compares unequal to itself; it reads as 0,
    // as does an undriven net (which holds 0.0).
    function automatic logic v2l(input real v, input real vdd);
        logic bit_l;
        bit_l = 1'b0;
        if (v == v) begin
            bit_l = (v >= vth(vdd));
        end
        return bit_l;
    endfunction

    // Outputs are driven strictly rail to rail.
    function automatic real l2v(input logic b, input real vdd);
        return b ? vdd : 0.0;
    endfunction

endpackage

// File: rtl/sram_v2l.sv
// Purpose: per-bit conversion of a vector of voltages into logic levels.
// Latency: combinational, zero cycles.
// Backpressure: none.
module sram_v2l
    import sram_mixed_readfirst_pkg::*;
#(
    parameter int  WIDTH = 1,
    parameter real VDD   = VDD_DEFAULT
) (
    input  real              i_v [WIDTH-1:0],
    output logic [WIDTH-1:0] o_l
);

    // Threshold every bit independently against half the supply.
    always_comb begin
        o_l = '0;
        for (int k = 0; k < WIDTH; k++) begin
            o_l[k] = v2l(i_v[k], VDD);
        end
    end

endmodule

// File: rtl/sram_mixed_readfirst.sv
// Purpose: single-port read-first SRAM with voltage-domain ports and a purely digital core.
// Latency: one clock edge from address to dout; dout holds between edges.
// Backpressure: none; every active edge performs a read and an optional write.
module sram_mixed_readfirst
    import sram_mixed_readfirst_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ADDR_WIDTH = 4,
    parameter real VDD        = VDD_DEFAULT
) (
    input  real clk,
    input  real rst,
    input  real we,
    input  real addr [ADDR_WIDTH-1:0],
    input  real din  [DATA_WIDTH-1:0],
    output real dout [DATA_WIDTH-1:0]
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Scalar controls gathered into one vector so a single converter handles them.
    real                   w_ctl_v [2:0];
    logic [2:0]            w_ctl;
    logic                  w_clk;
    logic                  w_rst;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;

    // Bundle the scalar control voltages for conversion.
    always_comb begin
        w_ctl_v[0] = clk;
        w_ctl_v[1] = rst;
        w_ctl_v[2] = we;
    end

    sram_v2l #(
        .WIDTH (3),
        .VDD   (VDD)
    ) u_ctl_v2l (
        .i_v (w_ctl_v),
        .o_l (w_ctl)
    );

    sram_v2l #(
        .WIDTH (ADDR_WIDTH),
        .VDD   (VDD)
    ) u_addr_v2l (
        .i_v (addr),
        .o_l (w_addr)
    );

    sram_v2l #(
        .WIDTH (DATA_WIDTH),
        .VDD   (VDD)
    ) u_din_v2l (
        .i_v (din),
        .o_l (w_din)
    );

    assign w_clk = w_ctl[0];
    assign w_rst = w_ctl[1];
    assign w_we  = w_ctl[2];

    // Read-first core: the old word is captured before any write lands; reset clears everything at once.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_dout <= '0;
        end else begin
            r_dout <= r_mem[w_addr];
            if (w_we) begin
                r_mem[w_addr] <= w_din;
            end
        end
    end

    // Drive each read bit to a rail voltage.
    always_comb begin
        for (int k = 0; k < DATA_WIDTH; k++) begin
            dout[k] = l2v(r_dout[k], VDD);
        end
    end

endmodule

// File: tb/tb_sram_mixed_readfirst.sv
module tb_sram_mixed_readfirst;

    real clk = 0.0;
    real rst = 0.0;
    real we  = 0.0;
    real addr [3:0];
    real din  [7:0];
    real dout [7:0];

    logic clk_phase = 1'b0;
    real  clk_hi    = 1.8;
    real  clk_lo    = 0.0;
    real  nanv;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: an array of words and the last word read.
    logic [7:0] m_mem [16];
    logic [7:0] m_dout;
    logic       m_rst;

    sram_mixed_readfirst #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .VDD        (1.8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    always #5 begin
        clk_phase = ~clk_phase;
        clk = clk_phase ? clk_hi : clk_lo;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mode 0: exact rails, 1: random voltages on the correct side of 0.9 V (incl. NaN for 0), 2: 0.8/1.0 V
    function automatic real vol(input logic b, input int mode);
        real v;
        int  r;
        v = 0.0;
        if (mode == 0) begin
            v = b ? 1.8 : 0.0;
        end else if (mode == 2) begin
            v = b ? 1.0 : 0.8;
        end else begin
            r = int'($urandom_range(0, 4));
            if (b) begin
                case (r)
                    0: v = 0.9;
                    1: v = 1.0;
                    2: v = 1.5;
                    3: v = 1.8;
                    default: v = 2.0;
                endcase
            end else begin
                case (r)
                    0: v = 0.0;
                    1: v = 0.3;
                    2: v = 0.8;
                    3: v = 0.899;
                    default: v = nanv;
                endcase
            end
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
        m_dout = 8'h00;
    endtask

    // Decode dout voltages and compare against an expected word.
    task automatic check_dout(input string name, input logic [7:0] exp);
        logic [7:0] got;
        int         illegal;
        got     = 8'h00;
        illegal = 0;
        for (int k = 0; k < 8; k++) begin
            if (dout[k] == 1.8)      got[k] = 1'b1;
            else if (dout[k] == 0.0) got[k] = 1'b0;
            else                     illegal++;
        end
        n_cmp++;
        if (illegal != 0 || got !== exp) begin
            n_bad++;
            $display("FAIL %s: dout=0x%02h (non-rail bits=%0d) expected 0x%02h at %0t",
                     name, got, illegal, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] d, input int mode);
        we = vol(w, mode);
        for (int k = 0; k < 4; k++) addr[k] = vol(a[k], mode);
        for (int k = 0; k < 8; k++) din[k]  = vol(d[k], mode);
    endtask

    // One clock period: drive at negedge, advance the model at posedge, compare just after.
    task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                         input logic [7:0] d, input int mode);
        @(negedge clk_phase);
        rst   = vol(r, (mode == 1) ? 0 : mode);
        m_rst = r;
        if (r) model_clear();
        drive(w, a, d, mode);
        @(posedge clk_phase);
        if (!m_rst) begin
            m_dout = m_mem[a];
            if (w) m_mem[a] = d;
        end
        #1;
        check_dout("model", m_dout);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic async_reset();
        #2;
        rst   = 1.0;
        m_rst = 1'b1;
        model_clear();
        #1;
        check_dout("async_reset", 8'h00);
    endtask

    initial begin
        nanv = $bitstoreal(64'h7FF8000000000000);
        for (int k = 0; k < 4; k++) addr[k] = 0.0;
        for (int k = 0; k < 8; k++) din[k]  = 0.0;
        rst   = 1.8;
        m_rst = 1'b1;
        model_clear();

        // Writes during reset are ignored.
        cycle(1'b1, 1'b1, 4'd3, 8'hAA, 0);
        check_dout("reset_state", 8'h00);
        cycle(1'b1, 1'b1, 4'd7, 8'h77, 0);

        // Basic read-first sequence on address 3.
        cycle(1'b0, 1'b1, 4'd3, 8'hAA, 0);
        check_dout("write3_old", 8'h00);
        cycle(1'b0, 1'b0, 4'd3, 8'h00, 0);
        check_dout("read3_AA", 8'hAA);
        cycle(1'b0, 1'b1, 4'd3, 8'h55, 0);
        check_dout("write3_shows_old", 8'hAA);
        cycle(1'b0, 1'b0, 4'd3, 8'hFF, 0);
        check_dout("read3_55", 8'h55);
        cycle(1'b0, 1'b0, 4'd7, 8'h00, 0);
        check_dout("reset_write_ignored", 8'h00);

        // Extreme addresses, no aliasing.
        cycle(1'b0, 1'b1, 4'd15, 8'hFF, 0);
        cycle(1'b0, 1'b1, 4'd0,  8'h01, 0);
        cycle(1'b0, 1'b0, 4'd15, 8'h00, 0);
        check_dout("read15_FF", 8'hFF);
        cycle(1'b0, 1'b0, 4'd0,  8'h00, 0);
        check_dout("read0_01", 8'h01);

        // Marginal levels: 0.8 V is 0 and 1.0 V is 1, clock included.
        clk_hi = 1.0;
        clk_lo = 0.8;
        cycle(1'b0, 1'b1, 4'd5, 8'h3C, 2);
        cycle(1'b0, 1'b0, 4'd5, 8'hC3, 2);
        check_dout("weak_levels_3C", 8'h3C);
        cycle(1'b0, 1'b0, 4'd10, 8'h00, 2);
        check_dout("weak_addr10_empty", 8'h00);
        clk_hi = 1.8;
        clk_lo = 0.0;

        // Randomised traffic; between edges the inputs are scrambled and dout must not move.
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1);
            if (i % 3 == 0) begin
                #1;
                drive(1'b1, 4'($urandom), 8'($urandom), 1);
                #1;
                check_dout("hold_between_edges", m_dout);
            end
        end

        // Async reset mid-cycle after writes, then reads return zero.
        cycle(1'b0, 1'b1, 4'd3, 8'h5A, 0);
        cycle(1'b0, 1'b0, 4'd3, 8'h00, 0);
        check_dout("pre_reset_5A", 8'h5A);
        async_reset();
        cycle(1'b1, 1'b1, 4'd3, 8'hEE, 0);
        check_dout("held_in_reset", 8'h00);
        cycle(1'b0, 1'b0, 4'd3,  8'h00, 0);
        check_dout("after_reset_3", 8'h00);
        cycle(1'b0, 1'b0, 4'd15, 8'h00, 0);
        check_dout("after_reset_15", 8'h00);
        cycle(1'b0, 1'b0, 4'd0,  8'h00, 0);
        check_dout("after_reset_0", 8'h00);

        // Short random run after reset to confirm normal operation resumes.
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
